// File: rtl/alu_pkg.sv
// Shared types and default widths for the ALU command master and its latency timer.
package alu_pkg;

  localparam int ALU_DATA_W    = 8;
  localparam int ALU_OP_W      = 3;
  localparam int ALU_OUT_W     = 16;
  localparam int ALU_LAT_CNT_W = 4;

  typedef enum logic {
    ALU_MODE_A = 1'b0,
    ALU_MODE_B = 1'b1
  } alu_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DRIVE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_IRQ_CLR = 3'd3,
    ST_RESP    = 3'd4
  } alu_cmd_state_e;

  typedef struct packed {
    alu_mode_e             mode;
    logic [ALU_OP_W-1:0]   op;
    logic [ALU_DATA_W-1:0] a;
    logic [ALU_DATA_W-1:0] b;
  } alu_cmd_t;

  // Statistics counters wrap naturally from 16'hFFFF to 16'h0000.
  function automatic logic [15:0] stat_inc(input logic [15:0] v);
    return v + 16'd1;
  endfunction

endpackage

// File: rtl/alu_lat_timer.sv
// Down-counter that measures the fixed ALU result latency; o_done is registered
// and rises in the last WAIT cycle before alu_out is sampled.
module alu_lat_timer
  import alu_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_load,
  input  logic i_en,
  output logic o_done
);

  logic [ALU_LAT_CNT_W-1:0] r_cnt;

  // Load LATENCY-1 on DRIVE, then count down once per WAIT cycle.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt  <= '0;
      o_done <= 1'b0;
    end else if (i_load) begin
      r_cnt  <= ALU_LAT_CNT_W'(LATENCY - 1);
      o_done <= (LATENCY == 1);
    end else if (i_en) begin
      r_cnt  <= r_cnt - ALU_LAT_CNT_W'(1);
      o_done <= (r_cnt == ALU_LAT_CNT_W'(1));
    end
  end

endmodule

// File: rtl/alu_cmd_master.sv
// Drives the ALU pin interface for one host command at a time and returns the result.
// Optional macro ALU_CMD_STATS_EN adds accepted-command and irq-clear counters.
module alu_cmd_master
  import alu_pkg::*;
#(
  parameter int DATA_W  = ALU_DATA_W,
  parameter int OP_W    = ALU_OP_W,
  parameter int OUT_W   = ALU_OUT_W,
  parameter int LATENCY = 2
) (
  input  logic              alu_clk,
  input  logic              alu_rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_mode,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [OUT_W-1:0]  rsp_data,
  output logic              rsp_irq,
  output logic              alu_enable,
  output logic              alu_enable_a,
  output logic              alu_enable_b,
  output logic [OP_W-1:0]   alu_op_a,
  output logic [OP_W-1:0]   alu_op_b,
  output logic [DATA_W-1:0] alu_in_a,
  output logic [DATA_W-1:0] alu_in_b,
  output logic              alu_irq_clr,
  input  logic [OUT_W-1:0]  alu_out,
`ifdef ALU_CMD_STATS_EN
  output logic [15:0]       stat_cmd_cnt,
  output logic [15:0]       stat_irq_cnt,
`endif
  input  logic              alu_irq
);

  alu_cmd_state_e r_state;
  alu_cmd_t       w_cmd;
  logic           w_lat_load;
  logic           w_lat_en;
  logic           w_lat_done;

  assign w_cmd      = '{mode: alu_mode_e'(cmd_mode), op: cmd_op, a: cmd_a, b: cmd_b};
  assign w_lat_load = (r_state == ST_DRIVE);
  assign w_lat_en   = (r_state == ST_WAIT) && !w_lat_done;

  alu_lat_timer #(
    .LATENCY(LATENCY)
  ) u_lat_timer (
    .i_clk  (alu_clk),
    .i_rst_n(alu_rst_n),
    .i_load (w_lat_load),
    .i_en   (w_lat_en),
    .o_done (w_lat_done)
  );

  // Command sequencer; every pin and response output is a register updated here.
  always_ff @(posedge alu_clk) begin
    if (!alu_rst_n) begin
      r_state      <= ST_IDLE;
      cmd_ready    <= 1'b1;
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
      rsp_irq      <= 1'b0;
      alu_enable   <= 1'b0;
      alu_enable_a <= 1'b0;
      alu_enable_b <= 1'b0;
      alu_op_a     <= '0;
      alu_op_b     <= '0;
      alu_in_a     <= '0;
      alu_in_b     <= '0;
      alu_irq_clr  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            cmd_ready    <= 1'b0;
            alu_enable   <= 1'b1;
            alu_enable_a <= (w_cmd.mode == ALU_MODE_A);
            alu_enable_b <= (w_cmd.mode == ALU_MODE_B);
            alu_op_a     <= (w_cmd.mode == ALU_MODE_A) ? w_cmd.op : '0;
            alu_op_b     <= (w_cmd.mode == ALU_MODE_B) ? w_cmd.op : '0;
            alu_in_a     <= w_cmd.a;
            alu_in_b     <= w_cmd.b;
            r_state      <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          // Operands and opcodes stay on the pins; only the enables are one-shot.
          alu_enable   <= 1'b0;
          alu_enable_a <= 1'b0;
          alu_enable_b <= 1'b0;
          r_state      <= ST_WAIT;
        end
        ST_WAIT: begin
          if (w_lat_done) begin
            rsp_data <= alu_out;
            rsp_irq  <= alu_irq;
            if (alu_irq) begin
              alu_irq_clr <= 1'b1;
              r_state     <= ST_IRQ_CLR;
            end else begin
              rsp_valid <= 1'b1;
              r_state   <= ST_RESP;
            end
          end
        end
        ST_IRQ_CLR: begin
          alu_irq_clr <= 1'b0;
          rsp_valid   <= 1'b1;
          r_state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            r_state   <= ST_IDLE;
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          cmd_ready    <= 1'b1;
          rsp_valid    <= 1'b0;
          alu_enable   <= 1'b0;
          alu_enable_a <= 1'b0;
          alu_enable_b <= 1'b0;
          alu_irq_clr  <= 1'b0;
        end
      endcase
    end
  end

`ifdef ALU_CMD_STATS_EN
  // Accepted-command and IRQ_CLR-entry counters.
  always_ff @(posedge alu_clk) begin
    if (!alu_rst_n) begin
      stat_cmd_cnt <= 16'd0;
      stat_irq_cnt <= 16'd0;
    end else begin
      if ((r_state == ST_IDLE) && cmd_valid) begin
        stat_cmd_cnt <= stat_inc(stat_cmd_cnt);
      end
      if ((r_state == ST_WAIT) && w_lat_done && alu_irq) begin
        stat_irq_cnt <= stat_inc(stat_irq_cnt);
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_cmd_master.sv
// Scoreboard bench for alu_cmd_master: a behavioural ALU responder, a response
// monitor that also paces rsp_ready, and directed plus random command stimulus.
module tb_alu_cmd_master;
  import alu_pkg::*;

  localparam int LAT = 2;

  logic        alu_clk = 1'b0;
  logic        alu_rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_mode = 1'b0;
  logic [2:0]  cmd_op = 3'd0;
  logic [7:0]  cmd_a = 8'd0;
  logic [7:0]  cmd_b = 8'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_data;
  logic        rsp_irq;
  logic        alu_enable, alu_enable_a, alu_enable_b, alu_irq_clr;
  logic [2:0]  alu_op_a, alu_op_b;
  logic [7:0]  alu_in_a, alu_in_b;
  logic [15:0] alu_out = 16'd0;
  logic        alu_irq = 1'b0;
`ifdef ALU_CMD_STATS_EN
  logic [15:0] stat_cmd_cnt, stat_irq_cnt;
`endif

  alu_cmd_master #(.DATA_W(8), .OP_W(3), .OUT_W(16), .LATENCY(LAT)) dut (
    .alu_clk(alu_clk), .alu_rst_n(alu_rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_irq(rsp_irq),
    .alu_enable(alu_enable), .alu_enable_a(alu_enable_a), .alu_enable_b(alu_enable_b),
    .alu_op_a(alu_op_a), .alu_op_b(alu_op_b), .alu_in_a(alu_in_a), .alu_in_b(alu_in_b),
    .alu_irq_clr(alu_irq_clr), .alu_out(alu_out),
`ifdef ALU_CMD_STATS_EN
    .stat_cmd_cnt(stat_cmd_cnt), .stat_irq_cnt(stat_irq_cnt),
`endif
    .alu_irq(alu_irq)
  );

  always #5 alu_clk = ~alu_clk;

  int cyc = 0;
  always @(posedge alu_clk) cyc <= cyc + 1;

  typedef struct {
    logic        mode;
    logic [2:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] data;
    logic        irq;
    int          hs;
  } exp_t;

  exp_t rsp_q[$];
  exp_t drv_q[$];
  int   exp_clr = -1;
  int   force_stall = 0;
  int   n_cmd_model = 0;
  int   n_irq_model = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_event(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got event expected none (cycle %0d)", name, cyc);
  endtask

  // Behavioural ALU: returns {irq, result}; mode B raises irq on odd results.
  function automatic logic [16:0] alu_ref(input logic m, input logic [2:0] op,
                                          input logic [7:0] a, input logic [7:0] b);
    logic [15:0] ea, eb, r;
    ea = {8'h00, a};
    eb = {8'h00, b};
    case (op)
      3'd0:    r = ea + eb;
      3'd1:    r = ea - eb;
      3'd2:    r = ea * eb;
      3'd3:    r = ea & eb;
      3'd4:    r = ea | eb;
      3'd5:    r = ea ^ eb;
      3'd6:    r = {a, b};
      default: r = {b, a};
    endcase
    return {m & r[0], r};
  endfunction

  // ALU responder: checks the drive pins, presents the result only in the sampling cycle.
  initial begin
    int   k;
    logic prev_en;
    exp_t d;
    k = -1;
    prev_en = 1'b0;
    forever begin
      @(negedge alu_clk);
      #1;
      if (!alu_rst_n) begin
        k = -1;
        exp_clr = -1;
        prev_en = 1'b0;
        alu_out = 16'd0;
        alu_irq = 1'b0;
      end else begin
        if (alu_irq_clr || cyc == exp_clr)
          check("irq_clr_cycle", alu_irq_clr, (cyc == exp_clr));
        if (k > 0) k--;
        if (k == 0) begin
          alu_out = d.data;
          alu_irq = d.irq;
          if (d.irq) exp_clr = cyc + 1;
          k = -1;
        end else begin
          alu_out = 16'($urandom);
          alu_irq = 1'($urandom_range(0, 1));
        end
        if (alu_enable) begin
          check("enable_width", prev_en, 1'b0);
          if (drv_q.size() == 0) begin
            fail_event("unexpected_drive");
          end else begin
            d = drv_q.pop_front();
            check("drive_cycle", cyc, d.hs + 1);
            check("enable_a", alu_enable_a, !d.mode);
            check("enable_b", alu_enable_b, d.mode);
            check("op_a", alu_op_a, d.mode ? 3'd0 : d.op);
            check("op_b", alu_op_b, d.mode ? d.op : 3'd0);
            check("in_a", alu_in_a, d.a);
            check("in_b", alu_in_b, d.b);
            k = LAT;
          end
        end else if (alu_enable_a || alu_enable_b) begin
          fail_event("stray_enable");
        end
        prev_en = alu_enable;
      end
    end
  end

  // Response monitor: pops the scoreboard on each new response and paces rsp_ready.
  initial begin
    logic        pv, pr;
    logic [15:0] pd;
    int          stall;
    exp_t        e;
    pv = 1'b0;
    pr = 1'b0;
    pd = 16'd0;
    stall = -1;
    forever begin
      @(negedge alu_clk);
      #1;
      if (!alu_rst_n) begin
        pv = 1'b0;
        pr = 1'b0;
        stall = -1;
        rsp_ready = 1'b0;
      end else begin
        if (rsp_valid && !pv) begin
          if (rsp_q.size() == 0) begin
            fail_event("unexpected_rsp");
          end else begin
            e = rsp_q.pop_front();
            check("rsp_data", rsp_data, e.data);
            check("rsp_irq", rsp_irq, e.irq);
            check("rsp_cycle", cyc, e.hs + LAT + 2 + int'(e.irq));
            check("busy_cmd_ready", cmd_ready, 1'b0);
          end
        end else if (rsp_valid && pv && !pr) begin
          check("rsp_hold_data", rsp_data, pd);
          check("stall_cmd_ready", cmd_ready, 1'b0);
        end else if (rsp_valid && pv && pr) begin
          fail_event("rsp_not_dropped");
        end else if (!rsp_valid && pv && pr) begin
          check("cmd_ready_after_rsp", cmd_ready, 1'b1);
        end
        if (!rsp_valid) begin
          rsp_ready = 1'($urandom_range(0, 1));
          stall = -1;
        end else begin
          if (stall < 0) begin
            stall = (force_stall > 0) ? force_stall : int'($urandom_range(0, 3));
            force_stall = 0;
          end
          if (stall == 0) begin
            rsp_ready = 1'b1;
          end else begin
            rsp_ready = 1'b0;
            stall--;
          end
        end
        pv = rsp_valid;
        pr = rsp_ready;
        pd = rsp_data;
      end
    end
  end

  task automatic send(input logic m, input logic [2:0] op, input logic [7:0] a,
                      input logic [7:0] b, input int stall);
    exp_t        e;
    logic [16:0] r;
    int          waited;
    @(negedge alu_clk);
    cmd_valid = 1'b1;
    cmd_mode  = m;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    waited = 0;
    while (!cmd_ready && waited < 100) begin
      @(negedge alu_clk);
      waited++;
    end
    if (!cmd_ready) begin
      fail_event("cmd_accept_timeout");
      cmd_valid = 1'b0;
      return;
    end
    r = alu_ref(m, op, a, b);
    e.mode = m;
    e.op   = op;
    e.a    = a;
    e.b    = b;
    e.data = r[15:0];
    e.irq  = r[16];
    e.hs   = cyc;
    rsp_q.push_back(e);
    drv_q.push_back(e);
    n_cmd_model++;
    n_irq_model += int'(e.irq);
    if (stall > 0) force_stall = stall;
    @(negedge alu_clk);
    cmd_valid = 1'b0;
    cmd_a = 8'($urandom);
    cmd_b = 8'($urandom);
    cmd_op = 3'($urandom);
  endtask

  initial begin
    repeat (3) @(negedge alu_clk);
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_rsp", {rsp_valid, rsp_irq, rsp_data}, 32'd0);
    check("rst_pins", {alu_enable, alu_enable_a, alu_enable_b, alu_irq_clr,
                       alu_op_a, alu_op_b, alu_in_a, alu_in_b}, 32'd0);
    alu_rst_n = 1'b1;

    send(1'b0, 3'd0, 8'h12, 8'h34, 0);
    send(1'b1, 3'd2, 8'hFF, 8'h01, 0);
    send(1'b0, 3'd6, 8'hA5, 8'h3C, 5);
    send(1'b1, 3'd1, 8'h10, 8'h03, 0);

    // Reset while the in-flight command sits in WAIT: no clear, no response.
    repeat (12) @(negedge alu_clk);
    send(1'b1, 3'd5, 8'h01, 8'h00, 0);
    @(negedge alu_clk);
    alu_rst_n = 1'b0;
    @(negedge alu_clk);
    check("midrst_cmd_ready", cmd_ready, 1'b1);
    check("midrst_rsp", {rsp_valid, rsp_irq, rsp_data}, 32'd0);
    check("midrst_pins", {alu_enable, alu_enable_a, alu_enable_b, alu_irq_clr,
                          alu_op_a, alu_op_b, alu_in_a, alu_in_b}, 32'd0);
    rsp_q.delete();
    drv_q.delete();
    n_cmd_model = 0;
    n_irq_model = 0;
    alu_rst_n = 1'b1;
    repeat (10) @(negedge alu_clk);
    check("no_rsp_after_rst", rsp_valid, 1'b0);

    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge alu_clk);
      send(1'($urandom_range(0, 1)), 3'($urandom), 8'($urandom), 8'($urandom), 0);
    end

    for (int i = 0; i < 300 && rsp_q.size() != 0; i++) @(negedge alu_clk);
    if (rsp_q.size() != 0) fail_event("drain_timeout");
    repeat (4) @(negedge alu_clk);

`ifdef ALU_CMD_STATS_EN
    check("stat_cmd_cnt", stat_cmd_cnt, 16'(n_cmd_model));
    check("stat_irq_cnt", stat_irq_cnt, 16'(n_irq_model));
`endif

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
